// File: rtl/rx_phase_ctrl.sv
// Phase-ambiguity controller: hunts for the frame sync word by stepping iq_rot, then locks and supervises it.
// Optional build macro RX_PHASE_CTRL_INV_DETECT_EN adds inverted-sync (180 degree) detection during search.
module rx_phase_ctrl #(
  parameter int                  SYNC_LEN    = 32,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 32'h1ACFFC1D,
  parameter int                  PERIOD_BITS = 1056,
  parameter int                  SEARCH_BITS = 4096,
  parameter int                  MISS_MAX    = 3,
  parameter int                  RST_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out_data,
  output logic       out_sof,
  input  logic       out_ready,
  output logic [1:0] iq_rot,
  output logic       dp_rst,
  output logic       locked
);

  localparam int SW = $clog2(SEARCH_BITS + 1);
  localparam int FW = $clog2(PERIOD_BITS + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_BITS - 1);
  localparam logic [FW-1:0] FRAME_LAST  = FW'(PERIOD_BITS - 1);
  localparam logic [MW-1:0] MISS_LIM    = MW'(MISS_MAX);
  localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RST_DP,
    S_SEARCH,
    S_LOCKED
  } state_t;

  state_t            state_q, state_d;
  // Only the newest SYNC_LEN-1 bits are stored; the incoming bit completes the window.
  logic [SYNC_LEN-2:0] sr_q, sr_d;
  logic [SW-1:0]     search_cnt_q, search_cnt_d;
  logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
  logic [MW-1:0]     miss_cnt_q, miss_cnt_d;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [1:0]        iq_rot_q, iq_rot_d;
  logic              dp_rst_q, dp_rst_d;
  logic              locked_q, locked_d;

  logic              is_locked;
  logic              beat;
  logic [SYNC_LEN-1:0] window;
  logic              hit;
  logic              inv_hit;

  assign is_locked = (state_q == S_LOCKED);
  assign in_ready  = is_locked ? out_ready : 1'b1;
  assign out_valid = in_valid & is_locked;
  assign out_data  = in_data;
  assign out_sof   = out_valid & (frame_cnt_q == '0);
  assign beat      = in_valid & in_ready;
  assign window    = {sr_q, in_data};
  assign hit       = beat & (window == SYNC_WORD);
`ifdef RX_PHASE_CTRL_INV_DETECT_EN
  assign inv_hit   = beat & (window == ~SYNC_WORD);
`else
  assign inv_hit   = 1'b0;
`endif

  assign iq_rot = iq_rot_q;
  assign dp_rst = dp_rst_q;
  assign locked = locked_q;

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    search_cnt_d = search_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    iq_rot_d     = iq_rot_q;
    dp_rst_d     = dp_rst_q;
    locked_d     = locked_q;

    if (beat) sr_d = window[SYNC_LEN-2:0];

    case (state_q)
      S_RST_DP: begin
        sr_d         = '0;
        search_cnt_d = '0;
        dp_rst_d     = 1'b1;
        if (rst_cnt_q == RST_LAST) begin
          rst_cnt_d = '0;
          dp_rst_d  = 1'b0;
          state_d   = S_SEARCH;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_SEARCH: begin
        if (beat) begin
          search_cnt_d = search_cnt_q + 1'b1;
          // Priority: true sync, then inverted sync, then timeout.
          if (hit) begin
            state_d      = S_LOCKED;
            frame_cnt_d  = '0;
            miss_cnt_d   = '0;
            locked_d     = 1'b1;
            search_cnt_d = '0;
          end else if (inv_hit) begin
            iq_rot_d = iq_rot_q + 2'd2;
            dp_rst_d = 1'b1;
            state_d  = S_RST_DP;
          end else if (search_cnt_q == SEARCH_LAST) begin
            iq_rot_d = iq_rot_q + 2'd1;
            dp_rst_d = 1'b1;
            state_d  = S_RST_DP;
          end
        end
      end
      S_LOCKED: begin
        if (beat) begin
          frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 1'b1;
          if (frame_cnt_q == FRAME_LAST) begin
            if (hit) begin
              miss_cnt_d = '0;
            end else if (miss_cnt_q + 1'b1 == MISS_LIM) begin
              miss_cnt_d = '0;
              locked_d   = 1'b0;
              iq_rot_d   = iq_rot_q + 2'd1;
              dp_rst_d   = 1'b1;
              state_d    = S_RST_DP;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_RST_DP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RST_DP;
      sr_q         <= '0;
      search_cnt_q <= '0;
      frame_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      rst_cnt_q    <= '0;
      iq_rot_q     <= 2'd0;
      dp_rst_q     <= 1'b1;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      search_cnt_q <= search_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      iq_rot_q     <= iq_rot_d;
      dp_rst_q     <= dp_rst_d;
      locked_q     <= locked_d;
    end
  end

endmodule

// File: tb/tb_rx_phase_ctrl.sv
// Scoreboard bench for rx_phase_ctrl: stimulus queues expected status changes and SOF beats, a monitor pops them.
module tb_rx_phase_ctrl;

  localparam logic [31:0] SYNC = 32'h1ACFFC1D;
  localparam int          TO   = 4096 + 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_data, in_ready;
  logic       out_valid, out_data, out_sof, out_ready;
  logic [1:0] iq_rot;
  logic       dp_rst, locked;

  rx_phase_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sof  (out_sof),
    .out_ready(out_ready),
    .iq_rot   (iq_rot),
    .dp_rst   (dp_rst),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind 0: status {in_ready, dp_rst, locked, iq_rot} changed; kind 1: SOF beat carrying out_data
  typedef struct {
    bit         kind;
    bit         chk_t;
    logic [4:0] val;
    int         t;
  } ev_t;

  ev_t q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  bit  done        = 1'b0;

  function automatic logic [4:0] st(bit ir, bit dp, bit lk, logic [1:0] r);
    return {ir, dp, lk, r};
  endfunction

  task automatic expect_ev(bit kind, bit chk_t, logic [4:0] val, int t);
    ev_t e;
    e.kind = kind; e.chk_t = chk_t; e.val = val; e.t = t;
    q.push_back(e);
  endtask

  task automatic send_bit(logic b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // n_ev: expected status events tied to the last bit (one at its edge, optional second 64 cycles later)
  task automatic send_word(logic [31:0] w, int n_ev, logic [4:0] v1, logic [4:0] v2);
    logic [31:0] wr;
    wr = w;
    for (int i = 31; i >= 0; i--) begin
      if (i == 0 && n_ev > 0) expect_ev(1'b0, 1'b1, v1, cyc + 1);
      if (i == 0 && n_ev > 1) expect_ev(1'b0, 1'b1, v2, cyc + 1 + 64);
      send_bit(wr[i]);
    end
  endtask

  task automatic send_frame(bit good, bit drop, bit stall);
    logic pb;
    pb = 1'($urandom_range(0, 1));
    expect_ev(1'b1, 1'b1, {4'b0, pb}, cyc + 1);
    send_bit(pb);
    for (int i = 1; i < 1024; i++) begin
      if (stall && i == 500) begin
        expect_ev(1'b0, 1'b1, st(0, 0, 1, 0), cyc);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (100) begin
          in_data = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        expect_ev(1'b0, 1'b1, st(1, 0, 1, 0), cyc);
        out_ready = 1'b1;
      end
      send_bit(1'($urandom_range(0, 1)));
    end
    send_word(good ? SYNC : (SYNC ^ 32'h1), drop ? 2 : 0, st(1, 1, 0, 1), st(1, 0, 0, 1));
  endtask

  task automatic got(bit kind, logic [4:0] val, int t);
    ev_t e;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event kind=%0d val=%b t=%0d, required no event", kind, val, t);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val != val || (e.chk_t && e.t != t)) begin
        miscompares++;
        $display("FAIL event%0d got kind=%0d val=%b t=%0d, required kind=%0d val=%b t=%0d",
                 vectors, kind, val, t, e.kind, e.val, e.t);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic [4:0] prev, cur;
    bit         first;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(negedge clk);
      cur = st(in_ready, dp_rst, locked, iq_rot);
      if (first || cur != prev) begin
        got(1'b0, cur, cyc);
        prev  = cur;
        first = 1'b0;
      end
      if (out_valid && out_ready && out_sof) got(1'b1, {4'b0, out_data}, cyc + 1);
      if (done) begin
        while (q.size() > 0) begin
          ev_t e;
          e = q.pop_front();
          vectors++;
          miscompares++;
          $display("FAIL missing_event got none, required kind=%0d val=%b t=%0d", e.kind, e.val, e.t);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog got no completion, required finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, t0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 1'b0;
    out_ready = 1'b1;
    expect_ev(1'b0, 1'b0, st(1, 1, 0, 0), 0);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    expect_ev(1'b0, 1'b1, st(1, 0, 0, 0), cyc + 64);
    repeat (64) idle();

    // Lock at rotation 0, then good / stalled / missed frames.
    send_word(SYNC, 1, st(1, 0, 1, 0), '0);
    send_frame(1'b1, 1'b0, 1'b0);
    send_frame(1'b1, 1'b0, 1'b1);
    send_frame(1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0);
    send_frame(1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 1'b1, 1'b0);
    c0 = cyc;

    // Four search timeouts on a sync-free stream: rotation 1 -> 2 -> 3 -> 0 -> 1.
    for (int k = 1; k <= 4; k++) begin
      expect_ev(1'b0, 1'b1, st(1, 1, 0, 2'((1 + k) % 4)), c0 + k * TO);
      expect_ev(1'b0, 1'b1, st(1, 0, 0, 2'((1 + k) % 4)), c0 + k * TO + 64);
    end
    repeat (4 * TO + 64) send_bit(1'b0);

`ifdef RX_PHASE_CTRL_INV_DETECT_EN
    send_word(~SYNC, 2, st(1, 1, 0, 3), st(1, 0, 0, 3));
    repeat (70) idle();
`else
    t0 = cyc;
    expect_ev(1'b0, 1'b1, st(1, 1, 0, 2), t0 + 4096);
    expect_ev(1'b0, 1'b1, st(1, 0, 0, 2), t0 + 4096 + 64);
    send_word(~SYNC, 0, '0, '0);
    repeat (4096 - 32 + 64) send_bit(1'b0);
    repeat (6) idle();
`endif

    // Asynchronous reset mid-operation returns rotation to 0.
    expect_ev(1'b0, 1'b0, st(1, 1, 0, 0), 0);
    rst = 1'b1;
    repeat (3) idle();
    rst = 1'b0;
    expect_ev(1'b0, 1'b1, st(1, 0, 0, 0), cyc + 64);
    repeat (70) idle();
    done = 1'b1;
  end

endmodule
